// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the pipeline's memory-port arbitration.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arb_state_e;

  localparam logic [2:0]  FLAGS_WORD = 3'b010;
  localparam logic [31:0] NOP_INST   = 32'h00000013;

endpackage

// File: rtl/mem_arb_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
module mem_arb_timeout #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch port and the load/store port,
// with data priority, a fetch starvation bound and a hung-access timeout.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_flags,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_done,
  output logic [31:0]           d_rdata,
  output logic                  err,
  output logic                  stall_fetch,
  output logic                  stall_mem,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [2:0]            mem_flags,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES);
  localparam logic [3:0]  STREAK_MAX = 4'(DATA_STREAK_MAX);

  arb_state_e state;
  logic [3:0] streak;
  logic       grant_i, grant_d, busy, expired;

  // Data wins a tie unless fetch has already been passed over STREAK_MAX times.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (d_req && !(if_req && streak == STREAK_MAX)) grant_d = 1'b1;
      else if (if_req)                                grant_i = 1'b1;
    end
  end

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  mem_arb_timeout #(
    .WIDTH (TO_W)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .load       (grant_i | grant_d),
    .enable     (busy),
    .load_value (TO_W'(TIMEOUT_CYCLES - 1)),
    .expired    (expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_flags <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (!if_req) streak <= '0;
          if (grant_i) begin
            streak    <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_flags <= FLAGS_WORD;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= BUSY_I;
          end else if (grant_d) begin
            if (if_req && streak != STREAK_MAX) streak <= streak + 4'd1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_flags <= d_flags;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= BUSY_D;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (state == BUSY_I) if_rdata <= mem_rdata;
            else                 d_rdata  <= mem_rdata;
            if_done <= (state == BUSY_I);
            d_done  <= (state == BUSY_D);
            state   <= RESP;
          end else if (expired) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            if_done <= (state == BUSY_I);
            d_done  <= (state == BUSY_D);
            state   <= RESP;
          end
        end
        RESP: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          err     <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_fetch = if_req && !if_done;
  assign stall_mem   = d_req && !d_done;

  // A requester must hold its request through the whole access, done cycle included.
  a_if_held: assert property (@(posedge clock) disable iff (!reset)
    ((state == BUSY_I) || if_done) |-> if_req);
  a_d_held: assert property (@(posedge clock) disable iff (!reset)
    ((state == BUSY_D) || d_done) |-> d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences, random traffic vs. model.
module tb_mem_port_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned TO   = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_flags = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        err, stall_fetch, stall_mem;
  logic        mem_req, mem_we;
  logic [2:0]  mem_flags;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_STREAK_MAX (MAXS),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clock (clock), .reset (reset),
    .if_req (if_req), .if_addr (if_addr), .if_done (if_done), .if_rdata (if_rdata),
    .d_req (d_req), .d_we (d_we), .d_flags (d_flags), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_done (d_done), .d_rdata (d_rdata), .err (err),
    .stall_fetch (stall_fetch), .stall_mem (stall_mem),
    .mem_req (mem_req), .mem_we (mem_we), .mem_flags (mem_flags), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_ready (mem_ready), .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [2:0]  flags;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned lat;
    logic [31:0] rdata;
    logic        exp_we;
    logic [2:0]  exp_flags;
    logic [31:0] exp_wdata;
    int unsigned exp_done;
  } vec_t;

  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    tick();
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_flags = v.flags; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int unsigned k = 0; k <= v.exp_done; k++) begin
      if (k > 0) tick();
      mem_ready = (k == v.lat + 1);
      mem_rdata = mem_ready ? v.rdata : (32'hBAD0BAD0 ^ k);
      @(negedge clock);
      if (k >= 1 && k <= v.lat + 1) begin
        check("vec mem_req", mem_req, 1'b1);
        check("vec mem_bus", {mem_we, mem_flags, mem_addr, mem_wdata},
              {v.exp_we, v.exp_flags, v.addr, v.exp_wdata});
      end
      check("vec done", v.is_d ? d_done : if_done, k == v.exp_done);
    end
    check("vec rdata", v.is_d ? d_rdata : if_rdata, v.rdata);
    check("vec err/other", {err, v.is_d ? if_done : d_done}, 2'b00);
    tick();
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    check("vec pulse end", {if_done, d_done}, 2'b00);
    if (v.is_d) last_d = v.rdata;
    else        last_i = v.rdata;
  endtask

  task automatic run_random(input int unsigned ncyc);
    logic        i_act = 1'b0, d_act = 1'b0, i_again = 1'b0, d_again = 1'b0;
    logic        busy, exp_idone, exp_ddone;
    int          cur = 0;
    int unsigned streak = 0, g_c = 0, ready_at = 0, done_at = 0, c = 0;
    logic [31:0] rd_val = '0;
    logic [67:0] exp_bus = '0;
    while ((c < ncyc || i_act || d_act || cur != 0) && c < ncyc + 200) begin
      tick();
      if (!i_act && c < ncyc && (i_again || $urandom_range(0, 2) == 0)) begin
        i_act = 1'b1; if_addr = $urandom;
      end
      if (!d_act && c < ncyc && (d_again || $urandom_range(0, 2) == 0)) begin
        d_act = 1'b1; d_we = 1'($urandom_range(0, 1)); d_flags = 3'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      i_again = 1'b0; d_again = 1'b0;
      if_req = i_act; d_req = d_act;
      if (cur == 0) begin
        if (!i_act) streak = 0;
        if (i_act && (!d_act || streak == MAXS)) begin
          cur = 1; streak = 0; exp_bus = {1'b0, 3'b010, if_addr, 32'h0};
        end else if (d_act) begin
          cur = 2;
          if (i_act && streak < MAXS) streak++;
          exp_bus = {d_we, d_flags, d_addr, d_wdata};
        end
        if (cur != 0) begin
          g_c = c; ready_at = c + 1 + $urandom_range(0, 3); done_at = ready_at + 1;
          rd_val = $urandom;
        end
      end
      busy = (cur != 0) && (c > g_c) && (c <= ready_at);
      mem_ready = busy ? (c == ready_at) : ($urandom_range(0, 3) == 0);
      mem_rdata = (busy && c == ready_at) ? rd_val : $urandom;
      @(negedge clock);
      exp_idone = (cur == 1) && (c == done_at);
      exp_ddone = (cur == 2) && (c == done_at);
      check("rnd dones", {if_done, d_done, err}, {exp_idone, exp_ddone, 1'b0});
      check("rnd stalls", {stall_fetch, stall_mem}, {i_act && !exp_idone, d_act && !exp_ddone});
      if (busy) begin
        check("rnd mem_req", mem_req, 1'b1);
        check("rnd mem_bus", {mem_we, mem_flags, mem_addr, mem_wdata}, exp_bus);
      end else if (cur == 0 || c == g_c) begin
        check("rnd idle mem_req", mem_req, 1'b0);
      end
      if (exp_idone) begin
        check("rnd if_rdata", if_rdata, rd_val);
        i_act = 1'b0; i_again = 1'($urandom_range(0, 1)); cur = 0;
      end
      if (exp_ddone) begin
        check("rnd d_rdata", d_rdata, rd_val);
        d_act = 1'b0; d_again = 1'($urandom_range(0, 1)); cur = 0;
      end
      c++;
    end
    check("rnd drained", {i_act, d_act, 1'(cur != 0)}, 3'b000);
    tick();
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
  endtask

  vec_t vecs[5];
  logic [9:0] fetch_turn;

  initial begin
    vecs[0] = '{is_d: 1'b0, we: 1'b0, flags: 3'b000, addr: 32'h0000_0100, wdata: 32'h0,
                lat: 0, rdata: 32'h0050_0093, exp_we: 1'b0, exp_flags: 3'b010,
                exp_wdata: 32'h0, exp_done: 2};
    vecs[1] = '{is_d: 1'b1, we: 1'b1, flags: 3'b001, addr: 32'h0000_2000, wdata: 32'hDEAD_BEEF,
                lat: 3, rdata: 32'h1234_5678, exp_we: 1'b1, exp_flags: 3'b001,
                exp_wdata: 32'hDEAD_BEEF, exp_done: 5};
    vecs[2] = '{is_d: 1'b1, we: 1'b0, flags: 3'b100, addr: 32'h0000_3004, wdata: 32'h0000_0055,
                lat: 1, rdata: 32'hCAFE_F00D, exp_we: 1'b0, exp_flags: 3'b100,
                exp_wdata: 32'h0000_0055, exp_done: 3};
    vecs[3] = '{is_d: 1'b0, we: 1'b0, flags: 3'b000, addr: 32'h0000_0104, wdata: 32'h0,
                lat: 2, rdata: 32'h0000_0013, exp_we: 1'b0, exp_flags: 3'b010,
                exp_wdata: 32'h0, exp_done: 4};
    vecs[4] = '{is_d: 1'b1, we: 1'b1, flags: 3'b010, addr: 32'h0000_4000, wdata: 32'hA5A5_A5A5,
                lat: 0, rdata: 32'h0F0F_0F0F, exp_we: 1'b1, exp_flags: 3'b010,
                exp_wdata: 32'hA5A5_A5A5, exp_done: 2};

    // Reset values.
    repeat (3) tick();
    @(negedge clock);
    check("reset ports a", {if_done, if_rdata, d_done, d_rdata, err}, '0);
    check("reset ports b", {stall_fetch, stall_mem, mem_req, mem_we, mem_flags, mem_addr, mem_wdata}, '0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Both requesters saturating: data wins until the streak bound lets fetch through.
    fetch_turn = 10'b10_0001_0000;
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0400;
    d_req = 1'b1; d_we = 1'b0; d_flags = 3'b010; d_addr = 32'h0000_8000; d_wdata = '0;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) tick();
      mem_ready = 1'b0;
      @(negedge clock);
      check("streak idle stall", {stall_fetch, stall_mem}, 2'b11);
      tick();
      mem_ready = 1'b1; mem_rdata = 32'h1000 + j;
      @(negedge clock);
      check("streak grant", {mem_req, mem_addr}, {1'b1, fetch_turn[j] ? 32'h0000_0400 : 32'h0000_8000});
      tick();
      mem_ready = 1'b0;
      @(negedge clock);
      check("streak done", {if_done, d_done, stall_fetch, stall_mem},
            {fetch_turn[j], !fetch_turn[j], !fetch_turn[j], fetch_turn[j]});
    end
    last_i = 32'h1009; last_d = 32'h1008;
    tick();
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clock);
    check("streak end idle", mem_req, 1'b0);

    // Memory never answers: abort after TO busy cycles with err.
    tick();
    d_req = 1'b1; d_we = 1'b0; d_flags = 3'b010; d_addr = 32'h0000_9000; mem_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      @(negedge clock);
      if (k <= 8) check("timeout busy", {mem_req, d_done, err}, 3'b100);
      else        check("timeout abort", {mem_req, d_done, err, d_rdata}, {3'b011, last_d});
    end
    tick();
    d_req = 1'b0;
    @(negedge clock);
    check("timeout clear", {err, d_done}, 2'b00);

    // Reset during BUSY_D, request held, access re-issued after release.
    tick();
    d_req = 1'b1; d_we = 1'b1; d_flags = 3'b000; d_addr = 32'h0000_A000; d_wdata = 32'h1111_2222;
    tick();
    @(negedge clock);
    check("rst busy", mem_req, 1'b1);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst sync", mem_req, 1'b1);
    tick();
    @(negedge clock);
    check("rst cleared", {mem_req, mem_we, d_done, err, d_rdata, if_rdata}, '0);
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("rst held", {mem_req, d_done}, 2'b00);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    @(negedge clock);
    check("rst reissue", {mem_req, mem_we, mem_addr}, {2'b11, 32'h0000_A000});
    tick();
    mem_ready = 1'b0;
    @(negedge clock);
    check("rst reissue done", {d_done, d_rdata}, {1'b1, 32'h0000_0077});
    last_d = 32'h0000_0077; last_i = '0;
    tick();
    d_req = 1'b0; d_we = 1'b0;

    // Spurious mem_ready while idle.
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_ready = 1'b1; mem_rdata = 32'hFFFF_0000 + k;
      @(negedge clock);
      check("spurious ready", {mem_req, if_done, d_done, err, d_rdata, if_rdata},
            {4'b0000, last_d, last_i});
    end
    tick();
    mem_ready = 1'b0;

    run_random(600);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
